// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl: sequences coefficient load, sample streaming, flush and latency-aligned output capture for an external FIR datapath
module fir_stream_ctrl #(
    parameter int M    = 7,
    parameter int TAPS = 5,
    parameter int LAT  = 1,
    localparam int AW  = (TAPS > 1) ? $clog2(TAPS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  coef_valid,
    input  logic signed [M-1:0]   coef_data,
    output logic                  coef_ready,
    input  logic                  in_valid,
    input  logic signed [M-1:0]   in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  coef_we,
    output logic [AW-1:0]         coef_addr,
    output logic [M-1:0]          coef_wdata,
    output logic                  filt_clr,
    output logic                  filt_en,
    output logic signed [M-1:0]   filt_in,
    input  logic signed [2*M-1:0] filt_out,
    output logic                  out_valid,
    output logic signed [2*M-1:0] out_data,
    output logic                  out_last,
    output logic                  busy
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, FLUSH, DRAIN} state_t;
    localparam int WW = $clog2(TAPS + 1);

    state_t                state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic [WW-1:0]         warm_q, warm_d;
    logic                  run_acc, flushing, emit, last_step, tap_v, tap_l;
    logic                  out_valid_q, out_last_q;
    logic signed [2*M-1:0] out_data_q;

    assign coef_ready = !rst && state_q == LOAD;
    assign in_ready   = !rst && state_q == RUN;
    assign coef_we    = coef_ready && coef_valid;
    assign coef_addr  = coef_we ? cnt_q : '0;
    assign coef_wdata = coef_we ? coef_data : '0;
    assign filt_clr   = !rst && state_q == IDLE && start;
    assign run_acc    = in_ready && in_valid;
    assign flushing   = !rst && state_q == FLUSH;
    assign filt_en    = run_acc || flushing;
    assign filt_in    = run_acc ? in_data : '0;
    assign busy       = state_q != IDLE;
    assign last_step  = (TAPS == 1) ? (run_acc && in_last) : (flushing && cnt_q == AW'(TAPS - 2));
    assign emit       = filt_en && warm_q == WW'(TAPS - 1);
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;

    if (LAT == 0) begin : g_direct
        assign tap_v = emit;
        assign tap_l = emit && last_step;
    end else begin : g_pipe
        logic [LAT-1:0] v_q, l_q;
        // Delay each step's tag so it meets the filter result it produced
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= '0;
                l_q <= '0;
            end else begin
                v_q[0] <= emit;
                l_q[0] <= emit && last_step;
                for (int i = 1; i < LAT; i++) begin
                    v_q[i] <= v_q[i-1];
                    l_q[i] <= l_q[i-1];
                end
            end
        end
        assign tap_v = v_q[LAT-1];
        assign tap_l = l_q[LAT-1];
    end

    // Next state and counters; warm-up saturates once the delay line is full
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        warm_d  = (filt_en && !emit) ? warm_q + WW'(1) : warm_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD;
                cnt_d   = '0;
                warm_d  = '0;
            end
            LOAD: if (coef_we) begin
                state_d = (cnt_q == AW'(TAPS - 1)) ? RUN : LOAD;
                cnt_d   = (cnt_q == AW'(TAPS - 1)) ? '0 : cnt_q + AW'(1);
            end
            RUN: if (run_acc && in_last) begin
                state_d = (TAPS > 1) ? FLUSH : DRAIN;
                cnt_d   = '0;
            end
            FLUSH: begin
                state_d = last_step ? DRAIN : FLUSH;
                cnt_d   = cnt_q + AW'(1);
            end
            DRAIN: if (out_last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counters and the registered output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            warm_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            warm_q      <= warm_d;
            out_valid_q <= tap_v;
            out_last_q  <= tap_l;
            out_data_q  <= tap_v ? filt_out : '0;
        end
    end
endmodule
